// File: rtl/data_type_pkg.sv
// Shared datapath types: bfloat16 word, opcode and tag widths, FPU opcodes, response entry.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package data_type_pkg;

  localparam int BF16_W = 16;
  localparam int OP_W   = 4;
  localparam int TAG_W  = 4;

  typedef logic [BF16_W-1:0] bf16_t;
  typedef logic [OP_W-1:0]   op_t;
  typedef logic [TAG_W-1:0]  tag_t;

  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_MUL = 4'd1;

  // One queued response: result word, overflow flag and the command's tag.
  typedef struct packed {
    bf16_t data;
    logic  ovf;
    tag_t  tag;
  } rsp_t;

endpackage

// File: rtl/fpu.sv
// Combinational bfloat16 add/multiply for normal operands, truncating rounding.
// Latency: zero cycles, purely combinational.
// Backpressure: none; result follows the inputs every cycle.
module fpu
  import data_type_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [BF16_W-1:0] a_i,
  input  logic [BF16_W-1:0] b_i,
  output logic [BF16_W-1:0] out_o,
  output logic              overflow_o
);

  logic               sx, sy, s_r, zero_r;
  logic [7:0]         ex, ey, mx, my;
  logic [8:0]         s9, ph;
  logic [6:0]         man_r;
  logic signed [10:0] e_r;

  // Operate on unpacked fields, then pack with overflow/underflow handling.
  always_comb begin
    s_r        = 1'b0;
    zero_r     = 1'b1;
    man_r      = '0;
    e_r        = '0;
    s9         = '0;
    ph         = '0;
    out_o      = '0;
    overflow_o = 1'b0;
    // Larger magnitude goes to x so the add never needs a negative shift.
    if (a_i[14:0] >= b_i[14:0]) begin
      {sx, ex, mx} = {a_i[15], a_i[14:7], 1'b1, a_i[6:0]};
      {sy, ey, my} = {b_i[15], b_i[14:7], 1'b1, b_i[6:0]};
    end else begin
      {sx, ex, mx} = {b_i[15], b_i[14:7], 1'b1, b_i[6:0]};
      {sy, ey, my} = {a_i[15], a_i[14:7], 1'b1, a_i[6:0]};
    end
    case (op_i)
      OP_ADD: begin
        if (ex == 8'd0) begin
          zero_r = 1'b1;
        end else if (ey == 8'd0) begin
          {zero_r, s_r, man_r} = {1'b0, sx, mx[6:0]};
          e_r = {3'b000, ex};
        end else if (sx == sy) begin
          s9     = {1'b0, mx} + {1'b0, my >> (ex - ey)};
          zero_r = 1'b0;
          s_r    = sx;
          e_r    = {3'b000, ex};
          if (s9[8]) begin
            man_r = s9[7:1];
            e_r   = e_r + 11'sd1;
          end else begin
            man_r = s9[6:0];
          end
        end else begin
          s9 = {1'b0, mx} - {1'b0, my >> (ex - ey)};
          if (s9 != 9'd0) begin
            zero_r = 1'b0;
            s_r    = sx;
            e_r    = {3'b000, ex};
            for (int i = 0; i < 7; i++) begin
              if (!s9[7]) begin
                s9  = {s9[7:0], 1'b0};
                e_r = e_r - 11'sd1;
              end
            end
            man_r = s9[6:0];
          end
        end
      end
      OP_MUL: begin
        if (a_i[14:7] != 8'd0 && b_i[14:7] != 8'd0) begin
          ph     = 9'((16'({1'b1, a_i[6:0]}) * 16'({1'b1, b_i[6:0]})) >> 7);
          zero_r = 1'b0;
          s_r    = a_i[15] ^ b_i[15];
          e_r    = {3'b000, a_i[14:7]} + {3'b000, b_i[14:7]} - 11'sd127;
          if (ph[8]) begin
            man_r = ph[7:1];
            e_r   = e_r + 11'sd1;
          end else begin
            man_r = ph[6:0];
          end
        end
      end
      default: zero_r = 1'b1;
    endcase
    if (zero_r || e_r <= 0) begin
      out_o = '0;
    end else if (e_r >= 255) begin
      out_o      = {s_r, 8'hFF, 7'h00};
      overflow_o = 1'b1;
    end else begin
      out_o = {s_r, e_r[7:0], man_r};
    end
  end

endmodule

// File: rtl/fpu_seq_fifo.sv
// Response queue: DEPTH-entry FIFO of W-bit words with an occupancy count.
// Latency: a pushed word is visible at data_o the cycle after the push.
// Backpressure: none internally; the writer must not push while full without a pop.
module fpu_seq_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          pop_ok;

  assign pop_ok  = pop_i & (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_ok) rd_q <= rd_q + AW'(1);
      case ({push_i, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: registers bfloat16 commands into a combinational FPU and queues tagged results.
// Latency: 2 cycles from command acceptance to rsp_valid_o with an empty queue.
// Backpressure: cmd_ready_o drops when queued plus in-flight results would fill the queue.
module fpu_seq
  import data_type_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_op_i,
  input  logic [BF16_W-1:0] cmd_a_i,
  input  logic [BF16_W-1:0] cmd_b_i,
  input  logic              cmd_chain_i,
  input  logic [TAG_W-1:0]  cmd_tag_i,
  output logic [OP_W-1:0]   fpu_op_o,
  output logic [BF16_W-1:0] fpu_in1_o,
  output logic [BF16_W-1:0] fpu_in2_o,
  input  logic [BF16_W-1:0] fpu_out_i,
  input  logic              fpu_overflow_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BF16_W-1:0] rsp_data_o,
  output logic              rsp_overflow_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  input  logic              cnt_clr_i,
  output logic [7:0]        ovf_cnt_o
);

  localparam int          CW      = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(RSP_DEPTH);

  logic              iss_vld_q, iss_vld_d;
  logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [BF16_W-1:0] in1_q, in1_d, in2_q, in2_d, last_q, last_d;
  logic [7:0]        ovf_cnt_q, ovf_cnt_d;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       occ;
  logic              fifo_empty, accept;
  rsp_t              fifo_in, fifo_out;

  // Reserve a queue slot for the in-flight result, so a capture can never overflow.
  assign occ         = {1'b0, fifo_cnt} + {{CW{1'b0}}, iss_vld_q};
  assign cmd_ready_o = (occ < DEPTH_L);
  assign accept      = cmd_valid_i & cmd_ready_o;

  // Next state: issue registers, chained-operand select, last result, overflow counter.
  always_comb begin
    iss_vld_d = accept;
    iss_tag_d = iss_tag_q;
    op_d      = op_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    last_d    = last_q;
    ovf_cnt_d = ovf_cnt_q;
    if (accept) begin
      iss_tag_d = cmd_tag_i;
      op_d      = cmd_op_i;
      in2_d     = cmd_b_i;
      // A back-to-back chain takes the result still on the FPU outputs.
      if (cmd_chain_i) in1_d = iss_vld_q ? fpu_out_i : last_q;
      else             in1_d = cmd_a_i;
    end
    if (iss_vld_q) last_d = fpu_out_i;
    if (cnt_clr_i) begin
      ovf_cnt_d = 8'd0;
    end else if (iss_vld_q && fpu_overflow_i && ovf_cnt_q != 8'hFF) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  // State registers; reset drops any in-flight command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_vld_q <= 1'b0;
      iss_tag_q <= '0;
      op_q      <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      last_q    <= '0;
      ovf_cnt_q <= '0;
    end else begin
      iss_vld_q <= iss_vld_d;
      iss_tag_q <= iss_tag_d;
      op_q      <= op_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      last_q    <= last_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign fifo_in = '{data: fpu_out_i, ovf: fpu_overflow_i, tag: iss_tag_q};

  fpu_seq_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     ($bits(rsp_t))
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (iss_vld_q),
    .data_i  (fifo_in),
    .pop_i   (rsp_valid_o & rsp_ready_i),
    .data_o  (fifo_out),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign fpu_op_o       = op_q;
  assign fpu_in1_o      = in1_q;
  assign fpu_in2_o      = in2_q;
  assign rsp_valid_o    = ~fifo_empty;
  assign rsp_data_o     = fifo_out.data;
  assign rsp_overflow_o = fifo_out.ovf;
  assign rsp_tag_o      = fifo_out.tag;
  assign ovf_cnt_o      = ovf_cnt_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Bench for fpu_seq: scoreboard of expected responses checked by an independent monitor.
// Latency: checks the 2-cycle accept-to-response timing directly.
// Backpressure: exercises rsp_ready_i=0 holding and cmd_ready_o dropping.
module tb_fpu_seq;
  import data_type_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_i;

  // DUT with the default two-entry queue.
  logic        cmd_valid_i, cmd_ready_o, cmd_chain_i, fpu_overflow_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_overflow_o, cnt_clr_i;
  logic [3:0]  cmd_op_i, cmd_tag_i, fpu_op_o, rsp_tag_o;
  logic [15:0] cmd_a_i, cmd_b_i, fpu_in1_o, fpu_in2_o, fpu_out_i, rsp_data_o;
  logic [7:0]  ovf_cnt_o;

  // Second DUT with a four-entry queue, used for the mid-operation reset case.
  logic        b_cmd_valid_i, b_cmd_ready_o, b_cmd_chain_i, b_fpu_overflow_i;
  logic        b_rsp_valid_o, b_rsp_ready_i, b_rsp_overflow_o, b_cnt_clr_i;
  logic [3:0]  b_cmd_op_i, b_cmd_tag_i, b_fpu_op_o, b_rsp_tag_o;
  logic [15:0] b_cmd_a_i, b_cmd_b_i, b_fpu_in1_o, b_fpu_in2_o, b_fpu_out_i, b_rsp_data_o;
  logic [7:0]  b_ovf_cnt_o;

  fpu_seq #(.RSP_DEPTH(2)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_chain_i(cmd_chain_i), .cmd_tag_i(cmd_tag_i),
    .fpu_op_o(fpu_op_o), .fpu_in1_o(fpu_in1_o), .fpu_in2_o(fpu_in2_o),
    .fpu_out_i(fpu_out_i), .fpu_overflow_i(fpu_overflow_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_overflow_o(rsp_overflow_o), .rsp_tag_o(rsp_tag_o),
    .cnt_clr_i(cnt_clr_i), .ovf_cnt_o(ovf_cnt_o)
  );

  fpu u_fpu (.op_i(fpu_op_o), .a_i(fpu_in1_o), .b_i(fpu_in2_o),
             .out_o(fpu_out_i), .overflow_o(fpu_overflow_i));

  fpu_seq #(.RSP_DEPTH(4)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(b_cmd_valid_i), .cmd_ready_o(b_cmd_ready_o), .cmd_op_i(b_cmd_op_i),
    .cmd_a_i(b_cmd_a_i), .cmd_b_i(b_cmd_b_i), .cmd_chain_i(b_cmd_chain_i), .cmd_tag_i(b_cmd_tag_i),
    .fpu_op_o(b_fpu_op_o), .fpu_in1_o(b_fpu_in1_o), .fpu_in2_o(b_fpu_in2_o),
    .fpu_out_i(b_fpu_out_i), .fpu_overflow_i(b_fpu_overflow_i),
    .rsp_valid_o(b_rsp_valid_o), .rsp_ready_i(b_rsp_ready_i), .rsp_data_o(b_rsp_data_o),
    .rsp_overflow_o(b_rsp_overflow_o), .rsp_tag_o(b_rsp_tag_o),
    .cnt_clr_i(b_cnt_clr_i), .ovf_cnt_o(b_ovf_cnt_o)
  );

  fpu u_fpu4 (.op_i(b_fpu_op_o), .a_i(b_fpu_in1_o), .b_i(b_fpu_in2_o),
              .out_o(b_fpu_out_i), .overflow_o(b_fpu_overflow_i));

  rsp_t sb_q[$];
  rsp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshaked response is popped against the scoreboard head.
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got tag %h, required no response", rsp_tag_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_data", rsp_data_o, mon_e.data);
        chk("rsp_ovf", rsp_overflow_o, mon_e.ovf);
        chk("rsp_tag", rsp_tag_o, mon_e.tag);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with cmd_valid_i still high.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic chain, input logic [3:0] tag,
                      input logic [15:0] exp_d, input logic exp_o);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_chain_i = chain;
    cmd_tag_i   = tag;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!cmd_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: cmd_ready_o=0, required 1 for tag %h", tag);
      cmd_valid_i = 1'b0;
    end else begin
      sb_q.push_back('{data: exp_d, ovf: exp_o, tag: tag});
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    {cmd_valid_i, cmd_chain_i, cnt_clr_i} = '0;
    {cmd_op_i, cmd_tag_i, cmd_a_i, cmd_b_i} = '0;
    rsp_ready_i = 1'b1;
    {b_cmd_valid_i, b_cmd_chain_i, b_cnt_clr_i, b_rsp_ready_i} = '0;
    {b_cmd_op_i, b_cmd_tag_i, b_cmd_a_i, b_cmd_b_i} = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state.
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_fpu_op", fpu_op_o, 4'h0);
    chk("rst_fpu_in1", fpu_in1_o, 16'h0000);
    chk("rst_fpu_in2", fpu_in2_o, 16'h0000);
    chk("rst_ovf_cnt", ovf_cnt_o, 8'd0);

    // 1.0 + 2.0 = 3.0 with 2-cycle latency.
    send(OP_ADD, 16'h3F80, 16'h4000, 1'b0, 4'd3, 16'h4040, 1'b0);
    cmd_valid_i = 1'b0;
    chk("lat_n1_rsp_valid", rsp_valid_o, 1'b0);
    chk("issue_op", fpu_op_o, OP_ADD);
    chk("issue_in1", fpu_in1_o, 16'h3F80);
    chk("issue_in2", fpu_in2_o, 16'h4000);
    @(negedge clk_i);
    chk("lat_n2_rsp_valid", rsp_valid_o, 1'b1);
    drain();

    // 1+1=2 then chained 2*3=6; a stale last result (3.0) would give 9.0.
    send(OP_ADD, 16'h3F80, 16'h3F80, 1'b0, 4'd1, 16'h4000, 1'b0);
    send(OP_MUL, 16'hDEAD, 16'h4040, 1'b1, 4'd2, 16'h40C0, 1'b0);
    cmd_valid_i = 1'b0;
    cmd_chain_i = 1'b0;
    chk("fwd_in1", fpu_in1_o, 16'h4000);
    drain();

    // Backpressure: two accepts fill the queue, the third waits, head holds.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    send(OP_ADD, 16'h3F80, 16'h3F80, 1'b0, 4'd4, 16'h4000, 1'b0);
    send(OP_MUL, 16'h4000, 16'h4040, 1'b0, 4'd5, 16'h40C0, 1'b0);
    cmd_a_i   = 16'h4000;
    cmd_b_i   = 16'h4000;
    cmd_tag_i = 4'd6;
    chk("bp_ready_drop", cmd_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_ready_low", cmd_ready_o, 1'b0);
      chk("bp_hold_valid", rsp_valid_o, 1'b1);
      chk("bp_hold_data", rsp_data_o, 16'h4000);
      chk("bp_hold_tag", rsp_tag_o, 4'd4);
    end
    rsp_ready_i = 1'b1;
    send(OP_ADD, 16'h4000, 16'h4000, 1'b0, 4'd6, 16'h4080, 1'b0);
    cmd_valid_i = 1'b0;
    drain();

    // Overflow counting and saturation.
    for (int i = 0; i < 300; i++)
      send(OP_MUL, 16'h7F00, 16'h7F00, 1'b0, 4'(i), 16'h7F80, 1'b1);
    cmd_valid_i = 1'b0;
    drain();
    chk("ovf_saturate", ovf_cnt_o, 8'd255);
    cnt_clr_i = 1'b1;
    @(negedge clk_i);
    cnt_clr_i = 1'b0;
    chk("ovf_clear", ovf_cnt_o, 8'd0);
    send(OP_MUL, 16'h7F00, 16'h7F00, 1'b0, 4'hA, 16'h7F80, 1'b1);
    cmd_valid_i = 1'b0;
    cnt_clr_i   = 1'b1;
    @(negedge clk_i);
    cnt_clr_i = 1'b0;
    chk("ovf_clear_wins", ovf_cnt_o, 8'd0);
    send(OP_MUL, 16'h7F00, 16'h7F00, 1'b0, 4'hB, 16'h7F80, 1'b1);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk("ovf_inc_one", ovf_cnt_o, 8'd1);
    drain();

    // Reset with two queued responses and one in flight (four-entry DUT).
    b_cmd_valid_i = 1'b1;
    {b_cmd_op_i, b_cmd_a_i, b_cmd_b_i, b_cmd_tag_i} = {OP_ADD, 16'h3F80, 16'h3F80, 4'd7};
    @(posedge clk_i);
    @(negedge clk_i);
    {b_cmd_op_i, b_cmd_a_i, b_cmd_b_i, b_cmd_tag_i} = {OP_ADD, 16'h3F80, 16'h4000, 4'd8};
    @(posedge clk_i);
    @(negedge clk_i);
    {b_cmd_op_i, b_cmd_a_i, b_cmd_b_i, b_cmd_tag_i} = {OP_MUL, 16'h4000, 16'h4000, 4'd9};
    @(posedge clk_i);
    @(negedge clk_i);
    b_cmd_valid_i = 1'b0;
    chk("b_pre_rsp_valid", b_rsp_valid_o, 1'b1);
    chk("b_pre_cmd_ready", b_cmd_ready_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("b_rst_rsp_valid", b_rsp_valid_o, 1'b0);
    chk("b_rst_cmd_ready", b_cmd_ready_o, 1'b1);
    b_rsp_ready_i = 1'b1;
    b_cmd_valid_i = 1'b1;
    b_cmd_chain_i = 1'b1;
    {b_cmd_op_i, b_cmd_a_i, b_cmd_b_i, b_cmd_tag_i} = {OP_ADD, 16'h4040, 16'h3F80, 4'd10};
    @(posedge clk_i);
    @(negedge clk_i);
    b_cmd_valid_i = 1'b0;
    b_cmd_chain_i = 1'b0;
    chk("b_chain_in1_zero", b_fpu_in1_o, 16'h0000);
    chk("b_n1_rsp_valid", b_rsp_valid_o, 1'b0);
    @(negedge clk_i);
    chk("b_n2_rsp_valid", b_rsp_valid_o, 1'b1);
    chk("b_rsp_data", b_rsp_data_o, 16'h3F80);
    chk("b_rsp_tag", b_rsp_tag_o, 4'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 SHALL have parameter RSP_DEPTH, default 2, giving the number of response FIFO entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid_i (in, 1) and cmd_ready_o (out, 1): command handshake.
REQ-005 SHALL have port cmd_op_i, input, 4 bits: FPU opcode, passed through to the FPU unchanged.
REQ-006 SHALL have ports cmd_a_i and cmd_b_i, input, 16 bits each: bfloat16 operands.
REQ-007 SHALL have port cmd_chain_i, input, 1 bit: when set, replace operand A with the previous result.
REQ-008 SHALL have port cmd_tag_i, input, 4 bits: opaque ID returned with the result.
REQ-009 SHALL have ports fpu_op_o (out, 4), fpu_in1_o (out, 16) and fpu_in2_o (out, 16): registered drive to the combinational FPU.
REQ-010 SHALL have ports fpu_out_i (in, 16) and fpu_overflow_i (in, 1): FPU result and overflow flag.
REQ-011 SHALL have ports rsp_valid_o (out, 1) and rsp_ready_i (in, 1): response handshake.
REQ-012 SHALL have ports rsp_data_o (out, 16), rsp_overflow_o (out, 1) and rsp_tag_o (out, 4): the response payload.
REQ-013 SHALL have ports cnt_clr_i (in, 1) and ovf_cnt_o (out, 8): overflow event counter and its clear.

Function
REQ-014 SHALL accept a command in any cycle where cmd_valid_i and cmd_ready_o are both 1.
REQ-015 SHALL load fpu_op_o, fpu_in1_o, fpu_in2_o, the in-flight tag and the issue-valid bit at the edge that ends an acceptance cycle N, so the FPU is driven throughout cycle N+1.
REQ-016 SHALL clear issue-valid at the edge ending a cycle with no acceptance, and SHALL leave fpu_op_o, fpu_in1_o and fpu_in2_o holding their last values.
REQ-017 SHALL, in any cycle where issue-valid is 1, capture {fpu_out_i, fpu_overflow_i, tag} into the response FIFO and into the last-result register at the end of that cycle.
REQ-018 SHALL therefore present a result on rsp_* from cycle N+2 at the earliest; fixed latency is 2 cycles with an empty FIFO and rsp_ready_i=1.
REQ-019 SHALL sustain one command per cycle when the FIFO does not back up.
REQ-020 SHALL drive cmd_ready_o = (fifo_count + issue_valid) < RSP_DEPTH, using registered state only, with no combinational path from rsp_ready_i or cmd_valid_i.
REQ-021 SHALL, for a chained command, set fpu_in1_o to fpu_out_i when issue-valid is 1 in the acceptance cycle (forwarding of the back-to-back result), and otherwise to the last-result register; cmd_a_i is ignored.
REQ-022 SHALL never overflow the response FIFO; a push and a pop in the same cycle SHALL leave the count unchanged and SHALL be legal at any occupancy.
REQ-023 SHALL drive rsp_valid_o = FIFO not empty, with the FIFO head on rsp_data_o, rsp_overflow_o and rsp_tag_o, and SHALL pop on rsp_valid_o && rsp_ready_i.
REQ-024 SHALL keep the response payload stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-025 SHALL increment ovf_cnt_o on each capture with fpu_overflow_i=1, saturating at 255.
REQ-026 SHALL, when cnt_clr_i and an increment occur in the same cycle, clear the counter to 0 (clear wins).
REQ-027 SHALL deliver responses in command order.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, force issue-valid=0, FIFO empty, rsp_valid_o=0, cmd_ready_o=1, fpu_op_o=0, fpu_in1_o=0, fpu_in2_o=0, last-result=0x0000 and ovf_cnt_o=0.
REQ-029 SHALL discard any in-flight command and all queued responses when reset is asserted mid-operation; nothing is captured in the reset cycle.

Structure
REQ-030 SHALL take the bfloat16 word typedef, the opcode width (4) and the tag width constant from the shared data_type_pkg.
REQ-031 SHALL place the response FIFO in a sub-module fpu_seq_fifo (parameterised depth and width, count output); the issue stage and the counter stay in fpu_seq.

Verification (bench instantiates fpu as the load; ADD and MUL use the package encodings)
REQ-032 SHALL cover this case: ADD 0x3F80 + 0x4000, tag 3, rsp_ready_i=1 -> rsp_data_o=0x4040, tag 3, rsp_valid_o rises 2 cycles after acceptance.
REQ-033 SHALL cover this case: back-to-back ADD 0x3F80+0x3F80, then chained MUL with b=0x4040 -> second result 0x40C0, proving forwarding.
REQ-034 SHALL cover this case: rsp_ready_i=0 with RSP_DEPTH=2 -> cmd_ready_o drops after 2 accepts, payload holds, and order is preserved after release.
REQ-035 SHALL cover this case: MUL 0x7F00 * 0x7F00 repeated 300 times -> rsp_overflow_o=1 on each response and ovf_cnt_o saturates at 255; cnt_clr_i together with an overflow event -> 0.
REQ-036 SHALL cover this case: rst_i pulsed with 2 queued responses and 1 in flight -> next cycle rsp_valid_o=0, cmd_ready_o=1, and a following chained op uses A=0x0000.
